tx_sweep_ctrl: RTL and testbench

TX_SWEEP_CTRL -- requirements
Module: tx_sweep_ctrl

---
 rtl/tx_sweep_ctrl_if.sv | 33 +++
 rtl/tx_sweep_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tx_sweep_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_sweep_ctrl_if.sv
// Bundle of sweep request/config inputs and tx-core drive outputs for tx_sweep_ctrl.
// master = sweep requester / tx-core side, slave = the sweep controller.
interface tx_sweep_ctrl_if #(
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic [15:0]        cfg_start_inc;
  logic [15:0]        cfg_stop_inc;
  logic [15:0]        cfg_step_inc;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [4:0]         cfg_output_select;
  logic [4:0]         mute_select;
  logic [4:0]         output_select;
  logic [15:0]        lo_dds_phase_inc;
  logic               busy;
  logic               done;
  logic               step_strobe;
  logic               cfg_error;
  logic [15:0]        step_index;

  modport master (
    output start, abort, cfg_start_inc, cfg_stop_inc, cfg_step_inc, cfg_dwell,
           cfg_output_select, mute_select,
    input  output_select, lo_dds_phase_inc, busy, done, step_strobe, cfg_error, step_index
  );

  modport slave (
    input  start, abort, cfg_start_inc, cfg_stop_inc, cfg_step_inc, cfg_dwell,
           cfg_output_select, mute_select,
    output output_select, lo_dds_phase_inc, busy, done, step_strobe, cfg_error, step_index
  );
endinterface

// File: rtl/tx_sweep_ctrl.sv
// Stepped-tone sweep controller: mutes the tx core around every LO phase-increment change.
// Define TX_SWEEP_LOOP_EN to restart the sweep from the start tone instead of finishing.
module tx_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int DWELL_W       = 16
) (
  input  logic           clock,
  input  logic           reset,
  tx_sweep_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_DWELL, S_STEP, S_DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t             r_state, w_state_next;
  logic [15:0]        r_stop_inc, w_stop_inc_next;
  logic [15:0]        r_step_inc, w_step_inc_next;
  logic [DWELL_W-1:0] r_dwell, w_dwell_next;
  logic [4:0]         r_osel_cfg, w_osel_cfg_next;
  logic [7:0]         r_settle_cnt, w_settle_cnt_next;
  logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_cnt_next;
  logic [4:0]         r_output_select, w_output_select_next;
  logic [15:0]        r_lo_inc, w_lo_inc_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic               r_strobe, w_strobe_next;
  logic               r_cfg_error, w_cfg_error_next;
  logic [15:0]        r_step_index, w_step_index_next;
`ifdef TX_SWEEP_LOOP_EN
  logic [15:0]        r_start_inc, w_start_inc_next;
`endif

  logic [16:0]        w_sum;
  logic               w_advance;
  logic               w_to_done;
  logic [DWELL_W-1:0] w_dwell_last;

  // 17-bit sum so a wrap past 0xFFFF ends the sweep instead of aliasing to a low tone
  assign w_sum        = {1'b0, r_lo_inc} + {1'b0, r_step_inc};
  assign w_advance    = !w_sum[16] && (w_sum[15:0] <= r_stop_inc) && (r_step_inc != 16'd0);
  assign w_dwell_last = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);

  always_comb begin
    w_state_next         = r_state;
    w_stop_inc_next      = r_stop_inc;
    w_step_inc_next      = r_step_inc;
    w_dwell_next         = r_dwell;
    w_osel_cfg_next      = r_osel_cfg;
    w_settle_cnt_next    = r_settle_cnt;
    w_dwell_cnt_next     = r_dwell_cnt;
    w_output_select_next = r_output_select;
    w_lo_inc_next        = r_lo_inc;
    w_busy_next          = r_busy;
    w_done_next          = 1'b0;
    w_strobe_next        = 1'b0;
    w_cfg_error_next     = r_cfg_error;
    w_step_index_next    = r_step_index;
`ifdef TX_SWEEP_LOOP_EN
    w_start_inc_next     = r_start_inc;
`endif
    w_to_done            = 1'b0;

    // abort pre-empts whatever the active states would otherwise do this cycle
    if (bus.abort && (r_state == S_SETTLE || r_state == S_DWELL || r_state == S_STEP)) begin
      w_to_done = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            w_stop_inc_next   = bus.cfg_stop_inc;
            w_step_inc_next   = bus.cfg_step_inc;
            w_dwell_next      = bus.cfg_dwell;
            w_osel_cfg_next   = bus.cfg_output_select;
`ifdef TX_SWEEP_LOOP_EN
            w_start_inc_next  = bus.cfg_start_inc;
`endif
            w_step_index_next = 16'd0;
            w_cfg_error_next  = 1'b0;
            if (bus.cfg_start_inc > bus.cfg_stop_inc) begin
              w_cfg_error_next = 1'b1;
              w_to_done        = 1'b1;
            end else begin
              w_state_next         = S_SETTLE;
              w_lo_inc_next        = bus.cfg_start_inc;
              w_busy_next          = 1'b1;
              w_output_select_next = bus.mute_select;
              w_settle_cnt_next    = SETTLE_LAST;
            end
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == 8'd0) begin
            w_state_next         = S_DWELL;
            w_output_select_next = r_osel_cfg;
            w_strobe_next        = 1'b1;
            w_dwell_cnt_next     = w_dwell_last;
          end else begin
            w_settle_cnt_next    = r_settle_cnt - 8'd1;
            w_output_select_next = bus.mute_select;
          end
        end
        S_DWELL: begin
          if (r_dwell_cnt == '0) begin
            w_state_next         = S_STEP;
            w_output_select_next = bus.mute_select;
          end else begin
            w_dwell_cnt_next = r_dwell_cnt - DWELL_W'(1);
          end
        end
        S_STEP: begin
          w_output_select_next = bus.mute_select;
          if (w_advance) begin
            w_lo_inc_next     = w_sum[15:0];
            w_step_index_next = r_step_index + 16'd1;
            w_state_next      = S_SETTLE;
            w_settle_cnt_next = SETTLE_LAST;
          end else begin
`ifdef TX_SWEEP_LOOP_EN
            // a zero step is a single-tone request and still finishes
            if (r_step_inc != 16'd0) begin
              w_lo_inc_next     = r_start_inc;
              w_step_index_next = 16'd0;
              w_state_next      = S_SETTLE;
              w_settle_cnt_next = SETTLE_LAST;
            end else begin
              w_to_done = 1'b1;
            end
`else
            w_to_done = 1'b1;
`endif
          end
        end
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end

    if (w_to_done) begin
      w_state_next         = S_DONE;
      w_done_next          = 1'b1;
      w_busy_next          = 1'b0;
      w_strobe_next        = 1'b0;
      w_output_select_next = bus.mute_select;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_stop_inc      <= 16'd0;
      r_step_inc      <= 16'd0;
      r_dwell         <= '0;
      r_osel_cfg      <= 5'd0;
      r_settle_cnt    <= 8'd0;
      r_dwell_cnt     <= '0;
      r_output_select <= 5'd0;
      r_lo_inc        <= 16'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_strobe        <= 1'b0;
      r_cfg_error     <= 1'b0;
      r_step_index    <= 16'd0;
`ifdef TX_SWEEP_LOOP_EN
      r_start_inc     <= 16'd0;
`endif
    end else begin
      r_state         <= w_state_next;
      r_stop_inc      <= w_stop_inc_next;
      r_step_inc      <= w_step_inc_next;
      r_dwell         <= w_dwell_next;
      r_osel_cfg      <= w_osel_cfg_next;
      r_settle_cnt    <= w_settle_cnt_next;
      r_dwell_cnt     <= w_dwell_cnt_next;
      r_output_select <= w_output_select_next;
      r_lo_inc        <= w_lo_inc_next;
      r_busy          <= w_busy_next;
      r_done          <= w_done_next;
      r_strobe        <= w_strobe_next;
      r_cfg_error     <= w_cfg_error_next;
      r_step_index    <= w_step_index_next;
`ifdef TX_SWEEP_LOOP_EN
      r_start_inc     <= w_start_inc_next;
`endif
    end
  end

  assign bus.output_select    = r_output_select;
  assign bus.lo_dds_phase_inc = r_lo_inc;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.step_strobe      = r_strobe;
  assign bus.cfg_error        = r_cfg_error;
  assign bus.step_index       = r_step_index;
endmodule

// File: tb/tb_tx_sweep_ctrl.sv
// Scoreboard bench for tx_sweep_ctrl: a tone-list model predicts strobe/done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_tx_sweep_ctrl;
  localparam int SETTLE = 8;
  localparam int DW     = 16;
`ifdef TX_SWEEP_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tx_sweep_ctrl_if #(.DWELL_W(DW)) bus ();
  tx_sweep_ctrl #(.SETTLE_CYCLES(SETTLE), .DWELL_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [15:0] inc;
    logic [15:0] idx;
    logic [4:0]  osel;
    bit          err;
    bit          chk;
  } ev_t;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   t0    = 0;
  logic [15:0] prev_lo = 16'd0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc - t0, act, req);
    end
  endtask

  function automatic int period_of(input int dw);
    return SETTLE + ((dw == 0) ? 1 : dw) + 1;
  endfunction

  // Tones are start, start+step, ... while <= stop; a zero step gives just one.
  function automatic int count_tones(input int s, input int p, input int st);
    int v, n;
    if (s > p) return 0;
    v = s;
    n = 0;
    do begin
      n++;
      v += st;
    end while (st != 0 && v <= p);
    return n;
  endfunction

  task automatic predict(input int s, input int p, input int st, input int dw,
                         input logic [4:0] osel, input logic [4:0] mute,
                         input int abort_at, input int reset_at, output int end_cyc);
    int per, n, natural, limit, kk;
    bit loops, aborted;
    ev_t e;
    per = period_of(dw);
    if (s > p) begin
      e.is_done = 1'b1; e.cyc = 1; e.inc = '0; e.idx = '0; e.osel = mute; e.err = 1'b1; e.chk = 1'b0;
      exp_q.push_back(e);
      end_cyc = 1;
      return;
    end
    n       = count_tones(s, p, st);
    loops   = LOOP && (st != 0);
    natural = loops ? 32'h3fff_ffff : 1 + n * per;
    aborted = (abort_at >= 1) && (abort_at < natural);
    if (reset_at >= 0)  limit = reset_at;
    else if (aborted)   limit = abort_at;
    else                limit = natural - 1;
    for (int k = 0; 1 + SETTLE + k * per <= limit; k++) begin
      e.is_done = 1'b0; e.cyc = 1 + SETTLE + k * per;
      e.inc = 16'(s + (k % n) * st); e.idx = 16'(k % n);
      e.osel = osel; e.err = 1'b0; e.chk = 1'b1;
      exp_q.push_back(e);
    end
    if (reset_at >= 0) begin
      end_cyc = reset_at + 1;
    end else begin
      if (aborted) begin
        end_cyc = abort_at + 1;
        kk = (abort_at - 1) / per;
      end else begin
        end_cyc = natural;
        kk = n - 1;
      end
      e.is_done = 1'b1; e.cyc = end_cyc;
      e.inc = 16'(s + (kk % n) * st); e.idx = 16'(kk % n);
      e.osel = mute; e.err = 1'b0; e.chk = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic handle_event();
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event at cycle %0d: done=%0b step_strobe=%0b, none expected",
               cyc - t0, bus.done, bus.step_strobe);
    end else begin
      e = exp_q.pop_front();
      check("event_kind_done", {31'd0, bus.done}, {31'd0, e.is_done});
      check("event_cycle", cyc - t0, e.cyc);
      check("event_output_select", {27'd0, bus.output_select}, {27'd0, e.osel});
      check("event_cfg_error", {31'd0, bus.cfg_error}, {31'd0, e.err});
      check("event_busy", {31'd0, bus.busy}, e.is_done ? 32'd0 : 32'd1);
      if (e.chk) begin
        check("event_phase_inc", {16'd0, bus.lo_dds_phase_inc}, {16'd0, e.inc});
        check("event_step_index", {16'd0, bus.step_index}, {16'd0, e.idx});
      end
    end
  endtask

  always @(negedge clock) begin
    if (bus.step_strobe === 1'b1 || bus.done === 1'b1) handle_event();
    if (bus.busy === 1'b1 && bus.lo_dds_phase_inc !== prev_lo)
      check("phase_change_while_muted", {27'd0, bus.output_select}, {27'd0, bus.mute_select});
    prev_lo <= bus.lo_dds_phase_inc;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_output_select"}, {27'd0, bus.output_select}, 32'd0);
    check({tag, "_phase_inc"}, {16'd0, bus.lo_dds_phase_inc}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_step_strobe"}, {31'd0, bus.step_strobe}, 32'd0);
    check({tag, "_cfg_error"}, {31'd0, bus.cfg_error}, 32'd0);
    check({tag, "_step_index"}, {16'd0, bus.step_index}, 32'd0);
  endtask

  task automatic run_sweep(input int s, input int p, input int st, input int dw,
                           input logic [4:0] osel, input logic [4:0] mute,
                           input int abort_in, input int reset_at, input string tag);
    int abort_at, end_cyc;
    bit err;
    abort_at = abort_in;
    err = (s > p);
    if (LOOP && !err && st != 0 && abort_at < 0 && reset_at < 0) abort_at = 5 * period_of(dw);
    @(posedge clock); #1;
    bus.cfg_start_inc     = 16'(s);
    bus.cfg_stop_inc      = 16'(p);
    bus.cfg_step_inc      = 16'(st);
    bus.cfg_dwell         = DW'(dw);
    bus.cfg_output_select = osel;
    bus.mute_select       = mute;
    bus.start             = 1'b1;
    t0 = cyc;
    predict(s, p, st, dw, osel, mute, abort_at, reset_at, end_cyc);
    $display("sweep %s: start=0x%04h stop=0x%04h step=0x%04h dwell=%0d abort@%0d reset@%0d end@%0d",
             tag, s, p, st, dw, abort_at, reset_at, end_cyc);
    for (int n = 1; n <= end_cyc + 2; n++) begin
      @(posedge clock); #1;
      if (n == 1) begin
        bus.start = 1'b0;
        if (err) begin
          check("err_busy_low", {31'd0, bus.busy}, 32'd0);
        end else begin
          check("start_busy", {31'd0, bus.busy}, 32'd1);
          check("start_phase_inc", {16'd0, bus.lo_dds_phase_inc}, 32'(s));
          check("start_step_index", {16'd0, bus.step_index}, 32'd0);
          check("start_muted", {27'd0, bus.output_select}, {27'd0, mute});
          check("start_cfg_error", {31'd0, bus.cfg_error}, 32'd0);
        end
      end
      if (n == 3 && !err) begin
        // restart request and config churn mid-sweep must both be ignored
        bus.start             = 1'b1;
        bus.cfg_start_inc     = 16'($urandom);
        bus.cfg_stop_inc      = 16'($urandom);
        bus.cfg_step_inc      = 16'($urandom);
        bus.cfg_dwell         = DW'($urandom);
        bus.cfg_output_select = 5'($urandom);
      end
      if (n == 4) bus.start = 1'b0;
      if (n == abort_at) bus.abort = 1'b1;
      if (n == abort_at + 1) bus.abort = 1'b0;
      if (n == reset_at) reset = 1'b1;
      if (n == reset_at + 1) begin
        reset = 1'b0;
        check_reset_values("mid_sweep_reset");
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("events_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("cfg_error_hold", {31'd0, bus.cfg_error}, {31'd0, err});
  endtask

  task automatic idle_start_abort(input bit exp_err);
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    t0 = cyc;
    $display("idle start+abort: expect no sweep");
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", {31'd0, bus.busy}, 32'd0);
    check("start_abort_cfg_error", {31'd0, bus.cfg_error}, {31'd0, exp_err});
    repeat (3) @(posedge clock);
    #1;
    check("start_abort_still_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, p, st, dw, ab, nt;
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.cfg_start_inc = '0; bus.cfg_stop_inc = '0; bus.cfg_step_inc = '0;
    bus.cfg_dwell = '0; bus.cfg_output_select = '0; bus.mute_select = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_values("reset");

    run_sweep(16'h1000, 16'h1300, 16'h0100, 4, 5'h0A, 5'h1F, -1, -1, "basic");
    run_sweep(16'h2000, 16'h1000, 16'h0100, 4, 5'h0A, 5'h1F, -1, -1, "cfg_error");
    idle_start_abort(1'b1);
    run_sweep(16'hFF00, 16'hFFFF, 16'h0080, 4, 5'h03, 5'h11, -1, -1, "carry");
    run_sweep(16'h1000, 16'h1300, 16'h0100, 4, 5'h0A, 5'h1F, 10, -1, "abort");
    run_sweep(16'h1000, 16'h1300, 16'h0100, 4, 5'h0A, 5'h1F, -1, 20, "reset");
    run_sweep(16'h1000, 16'h1300, 16'h0100, 4, 5'h0A, 5'h1F, -1, -1, "restart");
    run_sweep(16'h1234, 16'h1234, 16'h0010, 0, 5'h07, 5'h02, -1, -1, "start_eq_stop");
    run_sweep(16'h0100, 16'h0900, 16'h0000, 2, 5'h15, 5'h04, -1, -1, "step_zero");
`ifdef TX_SWEEP_LOOP_EN
    run_sweep(16'h1000, 16'h1300, 16'h0100, 4, 5'h0A, 5'h1F, 70, -1, "loop");
`endif

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        s = $urandom_range(1, 16'hFFFF);
        p = $urandom_range(0, s - 1);
      end else begin
        s = $urandom_range(0, 16'hFFFF);
        p = s + $urandom_range(0, 16'h0300);
        if (p > 16'hFFFF) p = 16'hFFFF;
      end
      st = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(16'h0040, 16'h0180);
      dw = $urandom_range(0, 5);
      nt = count_tones(s, p, st);
      ab = -1;
      if (nt > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(2, nt * period_of(dw));
      run_sweep(s, p, st, dw, 5'($urandom), 5'($urandom), ab, -1, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
